bitmap_idx_serializer: RTL and testbench

- Inverse companion of the lowest-set-bit one-hot isolator: the isolator reduces a bitmap to its highest-priority one-hot bit; this block walks an entire bitmap and emits every set bit, one per handshake.
- Each set bit is emitted as a one-hot vector plus its binary index, in priority order, on a valid/ready stream.
- Sits between request-vector producers (pending masks, completion bitmaps) and index-driven consumers such as table writes and per-entry service logic.

---
 rtl/bitmap_idx_serializer.sv | 98 +++++++++
 tb/tb_bitmap_idx_serializer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bitmap_idx_serializer.sv
// Walks a bitmap and emits each set bit as one-hot plus binary index on a valid/ready stream.
// Define BITMAP_SER_MSB_FIRST_EN to emit highest set bit first instead of lowest.
module bitmap_idx_serializer #(
    parameter int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iVld,
    output logic             iRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             oRdy,
    output logic [WIDTH-1:0] oOnehot,
    output logic [IDX_W-1:0] oIdx,
    output logic             oLast,
    output logic             oBusy
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_SCAN = 1'b1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] onehot;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             pop;
    logic             load;

    always_comb begin
`ifdef BITMAP_SER_MSB_FIRST_EN
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending_q[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
`else
        onehot = pending_q & (~pending_q + ONE);
`endif
    end

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = i[IDX_W-1:0];
            end
        end
    end

    // Single bit set: clearing the lowest set bit leaves nothing.
    assign last = (pending_q != '0) && ((pending_q & (pending_q - ONE)) == '0);

    assign oVld    = (state_q == STATE_SCAN);
    assign oBusy   = oVld;
    assign oOnehot = onehot;
    assign oIdx    = idx;
    assign oLast   = last;

    assign pop  = oVld & oRdy;
    assign iRdy = (state_q == STATE_IDLE) | (pop & last);
    assign load = iVld & iRdy;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (state_q == STATE_IDLE) begin
            if (load && (iDat != '0)) begin
                pending_d = iDat;
                state_d   = STATE_SCAN;
            end
        end else if (pop) begin
            if (!last) begin
                pending_d = pending_q & ~onehot;
            end else if (load && (iDat != '0)) begin
                pending_d = iDat;
            end else begin
                pending_d = '0;
                state_d   = STATE_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STATE_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_bitmap_idx_serializer.sv
// Scoreboard bench for bitmap_idx_serializer: accepted bitmaps expand into expected entries in a queue.
// Define BITMAP_SER_MSB_FIRST_EN to expect descending index order.
`timescale 1ns/100ps
module tb_bitmap_idx_serializer;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             iVld;
    logic             iRdy;
    logic [WIDTH-1:0] iDat;
    logic             oVld;
    logic             oRdy;
    logic [WIDTH-1:0] oOnehot;
    logic [IDX_W-1:0] oIdx;
    logic             oLast;
    logic             oBusy;

    bitmap_idx_serializer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .iVld(iVld), .iRdy(iRdy), .iDat(iDat),
        .oVld(oVld), .oRdy(oRdy), .oOnehot(oOnehot),
        .oIdx(oIdx), .oLast(oLast), .oBusy(oBusy)
    );

    always #10 clk = ~clk;

    int q_idx[$];
    bit q_last[$];
    int n_new;
    int checks;
    int passed;
    bit mon_en;
    bit prev_stall;
    logic [WIDTH-1:0] prev_onehot;
    logic [IDX_W-1:0] prev_idx;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: list of set-bit positions in emission order.
    task automatic push_bitmap(input logic [WIDTH-1:0] d);
        int ids[$];
        for (int i = 0; i < WIDTH; i++) if (d[i]) ids.push_back(i);
`ifdef BITMAP_SER_MSB_FIRST_EN
        ids.reverse();
`endif
        foreach (ids[k]) begin
            q_idx.push_back(ids[k]);
            q_last.push_back(k == ids.size() - 1);
        end
        n_new = ids.size();
    endtask

    task automatic cycle(input bit vld, input logic [WIDTH-1:0] dat, input bit ordy);
        bit exp_rdy;
        @(negedge clk);
        iVld = vld;
        iDat = dat;
        oRdy = ordy;
        n_new = 0;
        #2;
        exp_rdy = (q_idx.size() == 0) || (ordy && q_idx.size() == 1);
        chk("iRdy", int'(iRdy), int'(exp_rdy));
        if (iVld && iRdy) push_bitmap(dat);
    endtask

    // Monitor: compares whatever the DUT presents against the queue head.
    initial begin
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                chk("oVld", int'(oVld), int'(q_idx.size() > n_new));
                chk("oBusy", int'(oBusy), int'(oVld));
                if (prev_stall) begin
                    chk("stall_onehot", int'(oOnehot), int'(prev_onehot));
                    chk("stall_idx", int'(oIdx), int'(prev_idx));
                end
                if (oVld && q_idx.size() > n_new) begin
                    chk("oIdx", int'(oIdx), q_idx[0]);
                    chk("oOnehot", int'(oOnehot), 1 << q_idx[0]);
                    chk("oLast", int'(oLast), int'(q_last[0]));
                end
                prev_stall  = oVld && !oRdy;
                prev_onehot = oOnehot;
                prev_idx    = oIdx;
                if (oVld && oRdy && q_idx.size() > n_new) begin
                    void'(q_idx.pop_front());
                    void'(q_last.pop_front());
                end
            end
        end
    end

    initial begin
        int r;
        logic [WIDTH-1:0] d;
        checks = 0;
        passed = 0;
        n_new  = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        iVld   = 1'b0;
        iDat   = '0;
        oRdy   = 1'b0;
        #25;
        chk("rst_oVld", int'(oVld), 0);
        chk("rst_oOnehot", int'(oOnehot), 0);
        chk("rst_oIdx", int'(oIdx), 0);
        chk("rst_oLast", int'(oLast), 0);
        chk("rst_oBusy", int'(oBusy), 0);
        chk("rst_iRdy", int'(iRdy), 1);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Basic walk, stall, zero bitmap, full bitmap, back-to-back.
        cycle(1, 8'b1010_0100, 1);
        repeat (4) cycle(0, 8'h00, 1);
        cycle(1, 8'h03, 0);
        repeat (3) cycle(1, 8'hAA, 0);
        repeat (3) cycle(0, 8'h00, 1);
        cycle(1, 8'h00, 1);
        cycle(0, 8'h00, 1);
        cycle(1, 8'hFF, 1);
        repeat (9) cycle(0, 8'h00, 1);
        cycle(1, 8'h80, 1);
        cycle(1, 8'h01, 1);
        repeat (3) cycle(0, 8'h00, 1);

        // Asynchronous reset in the middle of a scan.
        cycle(1, 8'hF0, 1);
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_oVld", int'(oVld), 0);
        chk("midrst_oOnehot", int'(oOnehot), 0);
        chk("midrst_iRdy", int'(iRdy), 1);
        q_idx.delete();
        q_last.delete();
        prev_stall = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (3) cycle(0, 8'h00, 1);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            if (r == 0) d = 8'h00;
            else if (r == 1) d = 8'hFF;
            else d = 8'($urandom);
            cycle($urandom_range(0, 2) != 0, d, $urandom_range(0, 3) != 0);
        end

        // Drain with a bounded budget.
        for (int c = 0; c < 2 * WIDTH + 4 && q_idx.size() != 0; c++) cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 1);
        chk("drain_empty", q_idx.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
